exec_logic_unit: RTL and testbench
==================================

// Module: exec_logic_unit
// PURPOSE
//   Parametrised, registered logic unit for the pipelined execute stage: AND/OR/XOR/ANDN on
//   WIDTH-bit operands, one output register stage with valid/ready handshake.
//   Generates per-result condition codes and owns the architectural CC register (set_cc gated).
//   Sits between decode/execute operand latch and the memory-stage pipeline register; flush
//   kills the in-flight result on mispredict.
// PARAMETERS
//   WIDTH     64      operand/result width in bits (>= 2)
//   CC_RST    3'b100  reset value of the architectural CC register {ZF,SF,OF}
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   flush      in   1      synchronous kill of held result and of this cycle's accept
//   in_valid   in   1      operands/op valid this cycle
//   in_ready   out  1      unit can accept this cycle
//   op         in   2      0=AND, 1=OR, 2=XOR, 3=ANDN (a & ~b)
//   set_cc     in   1      write flags of this op into cc when accepted
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      y/co hold a valid result
//   out_ready  in   1      downstream consumes result this cycle
//   y          out  WIDTH  registered result
//   co         out  3      registered flags of y: co[2]=ZF, co[1]=SF, co[0]=OF
//   cc         out  3      architectural CC register, same bit layout as co
// BEHAVIOUR
//   Reset (rst=1 at edge): out_valid=0, y=0, co=3'b000, cc=CC_RST. rst overrides all inputs.
//   Combinational: r = op(a,b); ZF=(r==0); SF=r[WIDTH-1]; OF=0 (logic ops never overflow).
//   in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
//   accept = in_valid && in_ready && !flush.
//   Latency: 1 cycle; result of op accepted at edge N is visible on y/co after edge N.
//   Per edge, priority rst > flush > accept > hold:
//     flush:  out_valid<=0; y/co unchanged (don't care); cc NOT written even if set_cc=1.
//     accept: y<=r, co<={ZF,SF,0}, out_valid<=1; if set_cc then cc<={ZF,SF,0} same edge.
//     out_valid && out_ready && !accept: out_valid<=0 (result drained, bubble).
//     out_valid && !out_ready: y, co, out_valid held stable (stall); in_ready=0.
//   Simultaneous drain + accept (out_valid=1, out_ready=1, in_valid=1): old result leaves,
//     new result loaded same edge, out_valid stays 1 -> full throughput, 1 op/cycle.
//   cc only changes on accept with set_cc=1, or on rst; never on stall, drain, or flush.
//   set_cc is sampled only at accept; ignored when in_valid=0 or in_ready=0.
//   op, a, b, set_cc don't-care when in_valid=0; no X may propagate into y/co/cc.
//   Reset mid-stall: held result discarded, out_valid=0 the cycle after rst.
//   WIDTH generic: ZF reduces over all WIDTH bits, SF always bit WIDTH-1.
// TESTING
//   rst=1 two cycles -> out_valid=0, y=0, co=0, cc=3'b100, in_ready=1.
//   WIDTH=64, op=AND, a=0xFFFF_0000_0000_0000, b=0x8000_0000_0000_0001, set_cc=1 ->
//     next cycle y=0x8000_0000_0000_0000, co=3'b010, cc=3'b010, out_valid=1.
//   op=XOR, a=b=0x1234_5678_9ABC_DEF0, set_cc=0 -> y=0, co=3'b100, cc unchanged.
//   out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, y/co stable, cc unchanged;
//     out_ready=1 -> queued op accepted same edge the held result drains, out_valid stays 1.
//   Back-to-back ORs a=i, b=0 for i=1..8, out_ready=1 -> 8 results on consecutive cycles,
//     y=i in order; op=ANDN a=0xF0, b=0x30 -> y=0xC0, co=3'b000.
//   flush=1 with in_valid=1, set_cc=1, a=b=0 (ANDN) -> out_valid=0 next cycle, cc unchanged;
//     WIDTH=8 rerun: a=0x80,b=0xFF OR -> y=0xFF, co=3'b010.

Source files
------------

// File: rtl/exec_logic_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exec_logic_unit: registered AND/OR/XOR/ANDN execute unit with CC flags   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module exec_logic_unit #(
  parameter int         WIDTH  = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             set_cc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       co,
  output logic [2:0]       cc
);

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;

  logic [WIDTH-1:0] res;
  logic [2:0]       flags;
  logic             accept;

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = a & ~b;
    endcase
  end

  // Logic ops never overflow, so OF is constant zero.
  assign flags    = {~|res, res[WIDTH-1], 1'b0};
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      co        <= 3'b000;
      cc        <= CC_RST;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= res;
      co        <= flags;
      if (set_cc) begin
        cc <= flags;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_logic_unit.sv
`default_nettype none
// Scoreboard bench for exec_logic_unit: directed cases, then random traffic
// against a queue-based reference of the one-deep result register.
module tb_exec_logic_unit;

  localparam logic [2:0] CC_RST = 3'b100;

  typedef struct {
    logic [63:0] y;
    logic [2:0]  co;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, set_cc = 1'b0, out_ready = 1'b1;
  logic [1:0]  op = 2'd0;
  logic [63:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  logic [63:0] y;
  logic [2:0]  co, cc;

  logic        in_valid8 = 1'b0;
  logic [1:0]  op8 = 2'd0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8;
  logic [7:0]  y8;
  logic [2:0]  co8, cc8;

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  res_t sb[$];
  logic [2:0] exp_cc = CC_RST;

  always #5 clk = ~clk;

  exec_logic_unit #(.WIDTH(64), .CC_RST(CC_RST)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .set_cc(set_cc), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .co(co), .cc(cc)
  );

  exec_logic_unit #(.WIDTH(8), .CC_RST(CC_RST)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .set_cc(1'b1), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(1'b1), .y(y8), .co(co8), .cc(cc8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] z);
    res_t r;
    case (o)
      2'd0:    r.y = x & z;
      2'd1:    r.y = x | z;
      2'd2:    r.y = x ^ z;
      default: r.y = x & ~z;
    endcase
    r.co = {(r.y == 64'd0), r.y[63], 1'b0};
    return r;
  endfunction

  // One clock of stimulus; records the expected result of an accepted op.
  task automatic step(input logic r_i, input logic f_i, input logic iv, input logic [1:0] o,
                      input logic sc, input logic [63:0] x, input logic [63:0] z,
                      input logic ord);
    res_t e;
    rst = r_i; flush = f_i; in_valid = iv; op = o; set_cc = sc; a = x; b = z; out_ready = ord;
    @(posedge clk);
    if (rst) begin
      exp_cc = CC_RST;
    end else if (!flush && in_valid && in_ready) begin
      e = model(op, a, b);
      sb.push_back(e);
      if (set_cc) exp_cc = e.co;
    end
    #1;
  endtask

  // Monitor: checks presented outputs against the scoreboard head, pops on transfer/kill.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cc", {61'd0, cc}, {61'd0, exp_cc});
      chk("out_valid", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
      chk("in_ready", {63'd0, in_ready}, {63'd0, (sb.size() == 0) || out_ready});
      if (out_valid && sb.size() != 0) begin
        chk("y", y, sb[0].y);
        chk("co", {61'd0, co}, {61'd0, sb[0].co});
      end
      if (rst) sb.delete();
      else if (sb.size() != 0 && (flush || out_ready)) void'(sb.pop_front());
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y", y, 64'd0);
    chk("rst_co", {61'd0, co}, 64'd0);
    chk("rst_cc", {61'd0, cc}, 64'd4);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    mon_en = 1'b1;

    step(0, 0, 1, 2'd0, 1, 64'hFFFF_0000_0000_0000, 64'h8000_0000_0000_0001, 1);
    chk("and_y", y, 64'h8000_0000_0000_0000);
    chk("and_co", {61'd0, co}, 64'd2);
    chk("and_cc", {61'd0, cc}, 64'd2);
    step(0, 0, 1, 2'd2, 0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1);
    chk("xor_y", y, 64'd0);
    chk("xor_co", {61'd0, co}, 64'd4);
    chk("xor_cc", {61'd0, cc}, 64'd2);

    // Stall with a queued op, then release: drain and accept on the same edge.
    step(0, 0, 1, 2'd1, 1, 64'h55, 64'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd3, 1, 64'hFF, 64'h0F, 0);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    step(0, 0, 1, 2'd3, 1, 64'hFF, 64'h0F, 1);
    chk("release_valid", {63'd0, out_valid}, 64'd1);
    chk("release_y", y, 64'hF0);

    for (int i = 1; i <= 8; i++) step(0, 0, 1, 2'd1, 0, 64'(i), 64'd0, 1);
    step(0, 0, 1, 2'd3, 0, 64'hF0, 64'h30, 1);
    chk("andn_y", y, 64'hC0);
    chk("andn_co", {61'd0, co}, 64'd0);

    step(0, 1, 1, 2'd3, 1, 64'd0, 64'd0, 1);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_cc", {61'd0, cc}, 64'd0);

    in_valid8 = 1'b1; op8 = 2'd1; a8 = 8'h80; b8 = 8'hFF;
    step(0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 1);
    in_valid8 = 1'b0;
    chk("w8_valid", {63'd0, out_valid8}, 64'd1);
    chk("w8_y", {56'd0, y8}, 64'hFF);
    chk("w8_co", {61'd0, co8}, 64'd2);

    for (int i = 0; i < 600; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 1'($urandom), ra, rb, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
